// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI slave front end: MOSI frames to RAM command words, RAM read data to MISO
module spi_slave_ctrl #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [ADDR_SIZE+1:0]   rx_data,
    output logic                   rx_valid,
    input  logic [ADDR_SIZE-1:0]   tx_data,
    input  logic                   tx_valid
);

    localparam int RXW = ADDR_SIZE + 2;
    localparam int BW  = $clog2(RXW + 1);
    localparam int MW  = (ADDR_SIZE > 1) ? $clog2(ADDR_SIZE) : 1;

    // bit_cnt_q parks at BIT_DONE once a frame is complete so later MOSI bits are ignored
    localparam logic [BW-1:0] BIT_LAST  = BW'(RXW - 1);
    localparam logic [BW-1:0] BIT_DONE  = BW'(RXW);
    localparam logic [MW-1:0] MISO_LAST = MW'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   bit_cnt_q;
    logic [RXW-1:0]  shift_q;
    logic [MW-1:0]   miso_cnt_q;
    logic            rd_addr_held_q;
    logic            tx_busy_q;
    logic            tx_done_q;
    logic            miso_q;
    logic            rx_valid_q;
    logic [RXW-1:0]  rx_data_q;

    assign MISO     = miso_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

    // Frame FSM: command deserialisation, read-data capture and MISO serialisation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            miso_cnt_q     <= '0;
            rd_addr_held_q <= 1'b0;
            tx_busy_q      <= 1'b0;
            tx_done_q      <= 1'b0;
            miso_q         <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q != IDLE && SS_n) begin
                // Abort or normal frame end; a partial frame produces no strobe
                state_q    <= IDLE;
                bit_cnt_q  <= '0;
                miso_cnt_q <= '0;
                miso_q     <= 1'b0;
                tx_busy_q  <= 1'b0;
                tx_done_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        miso_q <= 1'b0;
                        if (!SS_n) begin
                            state_q <= CHK_CMD;
                        end
                    end
                    CHK_CMD: begin
                        bit_cnt_q <= '0;
                        if (!MOSI) begin
                            state_q <= WRITE;
                        end else if (rd_addr_held_q) begin
                            state_q <= READ_DATA;
                        end else begin
                            state_q <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bit_cnt_q != BIT_DONE) begin
                            shift_q   <= {shift_q[RXW-2:0], MOSI};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == BIT_LAST) begin
                                rx_data_q  <= {shift_q[RXW-2:0], MOSI};
                                rx_valid_q <= 1'b1;
                                if (state_q == READ_ADD) begin
                                    rd_addr_held_q <= 1'b1;
                                end
                            end
                        end else if (state_q == READ_DATA && !tx_done_q) begin
                            if (tx_busy_q) begin
                                miso_q     <= shift_q[ADDR_SIZE-1];
                                shift_q    <= {shift_q[RXW-2:0], 1'b0};
                                miso_cnt_q <= miso_cnt_q + 1'b1;
                                if (miso_cnt_q == MISO_LAST) begin
                                    tx_busy_q      <= 1'b0;
                                    tx_done_q      <= 1'b1;
                                    rd_addr_held_q <= 1'b0;
                                end
                            end else if (tx_valid) begin
                                shift_q    <= {2'b00, tx_data};
                                tx_busy_q  <= 1'b1;
                                miso_cnt_q <= '0;
                            end
                        end else begin
                            miso_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
